// File: rtl/multi_axis_integrator.sv
// -----------------------------------------------------------------------------
// multi_axis_integrator
//
// Multi-channel gyro angle integrator with optional accelerometer drift fusion.
// A single multiplier/adder datapath is shared across channels: after a sample
// is accepted, one channel is updated per clock, then all angles are published
// together with a one-cycle ang_vld strobe.
//
// Handshake: vld is a single-cycle strobe with no ready. A vld seen while the
// FSM is IDLE is accepted on that edge (rt/acc captured). A vld seen in any
// other state is dropped and sets the sticky ovr flag. busy is high while a
// sample is being processed (RUN and DONE), i.e. exactly when vld would be
// dropped.
//
// Ports:
//   clk        clock
//   rst        asynchronous active-high reset
//   vld        sample strobe
//   rt         packed gyro rates, channel k at [k*DW +: DW]
//   acc        packed accel readings, same packing
//   fusion_en  enable accel fusion (sampled as each channel is processed)
//   clr        synchronous clear, highest priority
//   ang        packed angles (integrator >> SHIFT), registered
//   ang_vld    one-cycle pulse when ang is updated
//   busy       sample in progress
//   sat        sticky per-channel saturation flags
//   ovr        sticky overrun flag
//   state_dbg  current FSM state (0 IDLE, 1 RUN, 2 DONE)
// -----------------------------------------------------------------------------
module multi_axis_integrator #(
    parameter int              NCH         = 2,
    parameter int              DW          = 16,
    parameter int              IW          = 27,
    parameter int              SHIFT       = 11,
    parameter logic [DW-1:0]   RT_OFFSET   = 16'h0050,
    parameter logic [DW-1:0]   AZ_OFFSET   = 16'h00A0,
    parameter int              ACC_GAIN    = 327,
    parameter int              FUSION_STEP = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                vld,
    input  logic [NCH*DW-1:0]   rt,
    input  logic [NCH*DW-1:0]   acc,
    input  logic                fusion_en,
    input  logic                clr,
    output logic [NCH*DW-1:0]   ang,
    output logic                ang_vld,
    output logic                busy,
    output logic [NCH-1:0]      sat,
    output logic                ovr,
    output logic [1:0]          state_dbg
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCH - 1);

    // Product width: DW-bit accel times a gain that fits comfortably in 16 bits.
    localparam int PW = DW + 16;

    // Signed DW range expressed at product width, for clamping acc_ang.
    localparam logic signed [PW-1:0] AMAX = {{(PW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [PW-1:0] AMIN = {{(PW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    // Integrator range expressed at IW+1 bits (one guard bit).
    localparam logic signed [IW:0] IMAX = {2'b00, {(IW-1){1'b1}}};
    localparam logic signed [IW:0] IMIN = {2'b11, {(IW-1){1'b0}}};

    logic [1:0]             state_q, state_d;
    logic [IDXW-1:0]        idx_q, idx_d;
    logic [NCH*DW-1:0]      rt_s_q;
    logic [NCH*DW-1:0]      acc_s_q;
    logic signed [IW-1:0]   int_q [NCH];
    logic [NCH*DW-1:0]      ang_q;
    logic                   ang_vld_q;
    logic [NCH-1:0]         sat_q;
    logic                   ovr_q;

    // Shared per-channel datapath signals
    logic signed [DW-1:0]   rt_c;
    logic signed [DW-1:0]   acc_c;
    logic signed [PW-1:0]   acc_w;
    logic signed [PW-1:0]   gain_w;
    logic signed [PW-1:0]   prod;
    logic signed [PW-1:0]   prod_sh;
    logic signed [DW-1:0]   acc_ang;
    logic signed [IW-1:0]   int_cur;
    logic signed [DW-1:0]   cur;
    logic signed [IW:0]     fus;
    logic signed [IW:0]     sum;
    logic signed [IW-1:0]   nxt_int;
    logic                   sat_hit;

    // ---------------------------------------------------------------- FSM
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (vld) begin
                    state_d = S_RUN;
                    idx_d   = '0;
                end
            end
            S_RUN: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- datapath
    always_comb begin
        rt_c    = rt_s_q[int'(idx_q)*DW +: DW] - RT_OFFSET;
        acc_c   = acc_s_q[int'(idx_q)*DW +: DW] - AZ_OFFSET;

        acc_w   = PW'(acc_c);
        gain_w  = PW'(ACC_GAIN);
        prod    = acc_w * gain_w;
        prod_sh = prod >>> 13;

        if (prod_sh > AMAX) begin
            acc_ang = AMAX[DW-1:0];
        end else if (prod_sh < AMIN) begin
            acc_ang = AMIN[DW-1:0];
        end else begin
            acc_ang = prod_sh[DW-1:0];
        end

        int_cur = int_q[idx_q];
        cur     = int_cur[IW-1:SHIFT];

        // Ties pull the integrator down, so equality yields -FUSION_STEP.
        if (!fusion_en) begin
            fus = '0;
        end else if (acc_ang > cur) begin
            fus = (IW+1)'(FUSION_STEP);
        end else begin
            fus = -((IW+1)'(FUSION_STEP));
        end

        // Gyro rate is subtracted: positive rate drives the angle negative.
        sum = (IW+1)'(int_cur) - (IW+1)'(rt_c) + fus;

        sat_hit = 1'b0;
        if (sum > IMAX) begin
            nxt_int = IMAX[IW-1:0];
            sat_hit = 1'b1;
        end else if (sum < IMIN) begin
            nxt_int = IMIN[IW-1:0];
            sat_hit = 1'b1;
        end else begin
            nxt_int = sum[IW-1:0];
        end
    end

    // ---------------------------------------------------------------- registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            rt_s_q    <= '0;
            acc_s_q   <= '0;
            ang_q     <= '0;
            ang_vld_q <= 1'b0;
            sat_q     <= '0;
            ovr_q     <= 1'b0;
            for (int k = 0; k < NCH; k++) begin
                int_q[k] <= '0;
            end
        end else if (clr) begin
            // clr wins over vld and the FSM; a coincident vld is dropped.
            state_q   <= S_IDLE;
            idx_q     <= '0;
            rt_s_q    <= '0;
            acc_s_q   <= '0;
            ang_q     <= '0;
            ang_vld_q <= 1'b0;
            sat_q     <= '0;
            ovr_q     <= 1'b0;
            for (int k = 0; k < NCH; k++) begin
                int_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            ang_vld_q <= 1'b0;

            if (state_q == S_IDLE && vld) begin
                rt_s_q  <= rt;
                acc_s_q <= acc;
            end

            if (state_q != S_IDLE && vld) begin
                ovr_q <= 1'b1;
            end

            if (state_q == S_RUN) begin
                int_q[idx_q] <= nxt_int;
                if (sat_hit) begin
                    sat_q[idx_q] <= 1'b1;
                end
            end

            // All channels are published in the same cycle so ang is coherent.
            if (state_q == S_DONE) begin
                for (int k = 0; k < NCH; k++) begin
                    ang_q[k*DW +: DW] <= int_q[k][IW-1:SHIFT];
                end
                ang_vld_q <= 1'b1;
            end
        end
    end

    assign ang       = ang_q;
    assign ang_vld   = ang_vld_q;
    assign busy      = (state_q != S_IDLE);
    assign sat       = sat_q;
    assign ovr       = ovr_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_multi_axis_integrator.sv
// -----------------------------------------------------------------------------
// tb_multi_axis_integrator
//
// Directed bench for multi_axis_integrator with default parameters (NCH=2).
// Inputs are driven on the falling edge, outputs sampled on the falling edge.
// Expected values are hand-computed from the integrator arithmetic:
//   rt_c = rt - 0x0050, integrator -= rt_c each sample, ang = int >>> 11.
// -----------------------------------------------------------------------------
module tb_multi_axis_integrator;

    logic        clk;
    logic        rst;
    logic        vld;
    logic [31:0] rt;
    logic [31:0] acc;
    logic        fusion_en;
    logic        clr;
    logic [31:0] ang;
    logic        ang_vld;
    logic        busy;
    logic [1:0]  sat;
    logic        ovr;
    logic [1:0]  state_dbg;

    int checks;
    int failures;
    int pulse_cnt;
    int base;
    int edges;

    multi_axis_integrator dut (
        .clk       (clk),
        .rst       (rst),
        .vld       (vld),
        .rt        (rt),
        .acc       (acc),
        .fusion_en (fusion_en),
        .clr       (clr),
        .ang       (ang),
        .ang_vld   (ang_vld),
        .busy      (busy),
        .sat       (sat),
        .ovr       (ovr),
        .state_dbg (state_dbg)
    );

    // ---------------------------------------------------------------- clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ang_vld pulse counter
    always @(negedge clk) begin
        if (ang_vld === 1'b1) pulse_cnt++;
    end

    // ---------------------------------------------------------------- helpers
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // One sample with 4-clock spacing; on return ang_vld for it is visible.
    task automatic send();
        vld = 1'b1;
        @(negedge clk);
        vld = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        checks    = 0;
        failures  = 0;
        pulse_cnt = 0;
        rst       = 1'b1;
        vld       = 1'b0;
        clr       = 1'b0;
        fusion_en = 1'b0;
        rt        = {16'h0050, 16'h0050};
        acc       = {16'h00A0, 16'h00A0};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ang", ang, 32'h0);
        chk("rst_ang_vld", {31'b0, ang_vld}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_sat", {30'b0, sat}, 32'h0);
        chk("rst_ovr", {31'b0, ovr}, 32'h0);
        chk("rst_state", {30'b0, state_dbg}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Rate integration: rt_c0 = 0x1000 -> int0 -= 4096 per sample
        rt   = {16'h0050, 16'h1050};
        base = pulse_cnt;
        send();
        chk("rate_first_ang0", {16'b0, ang[15:0]}, 32'h0000FFFE);
        repeat (499) send();
        @(negedge clk);
        chk("rate_ang0", {16'b0, ang[15:0]}, 32'h0000FC18);
        chk("rate_ang1", {16'b0, ang[31:16]}, 32'h0);
        chk("rate_pulses", pulse_cnt - base, 32'd500);

        // Reverse rate: int0 climbs back 4096 per sample
        rt = {16'h0050, 16'hF050};
        repeat (250) send();
        chk("rev_mid_ang0", {16'b0, ang[15:0]}, 32'h0000FE0C);
        repeat (250) send();
        chk("rev_ang0", {16'b0, ang[15:0]}, 32'h0);

        // Fusion: acc0 -> acc_ang=81, acc1 -> acc_ang=0
        clr = 1'b1;
        @(negedge clk);
        clr       = 1'b0;
        rt        = {16'h0050, 16'h0050};
        acc       = {16'h00A0, 16'h08A0};
        fusion_en = 1'b1;
        repeat (10) send();
        chk("fus10_ang0", {16'b0, ang[15:0]}, 32'd5);
        chk("fus10_ang1", {16'b0, ang[31:16]}, 32'h0);
        send();
        chk("fus11_ang0", {16'b0, ang[15:0]}, 32'd5);
        chk("fus11_ang1", {16'b0, ang[31:16]}, 32'h0000FFFF);
        repeat (159) send();
        chk("fus170_ang0", {16'b0, ang[15:0]}, 32'd81);
        chk("fus170_ang1", {16'b0, ang[31:16]}, 32'h0);
        send();
        chk("fus171_ang0", {16'b0, ang[15:0]}, 32'd80);

        // Saturation: rt_c0 = -32768 -> int0 += 32768 per sample
        clr = 1'b1;
        @(negedge clk);
        clr       = 1'b0;
        fusion_en = 1'b0;
        rt        = {16'h0050, 16'h8050};
        repeat (2047) send();
        chk("sat2047_ang0", {16'b0, ang[15:0]}, 32'h00007FF0);
        chk("sat2047_flag", {30'b0, sat}, 32'h0);
        send();
        chk("sat2048_ang0", {16'b0, ang[15:0]}, 32'h00007FFF);
        chk("sat2048_flag", {30'b0, sat}, 32'h1);
        rt = {16'h0050, 16'h0050};
        send();
        chk("sat_sticky", {30'b0, sat}, 32'h1);
        chk("sat_hold_ang0", {16'b0, ang[15:0]}, 32'h00007FFF);

        // Reset mid-RUN, with an overrun raised at E1 first
        vld = 1'b1;
        @(negedge clk);
        chk("mid_busy", {31'b0, busy}, 32'h1);
        @(negedge clk);
        vld = 1'b0;
        chk("mid_ovr_set", {31'b0, ovr}, 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("arst_ang", ang, 32'h0);
        chk("arst_ang_vld", {31'b0, ang_vld}, 32'h0);
        chk("arst_busy", {31'b0, busy}, 32'h0);
        chk("arst_sat", {30'b0, sat}, 32'h0);
        chk("arst_ovr", {31'b0, ovr}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Latency after release: ang_vld 3 edges after the accepting edge
        vld = 1'b1;
        @(negedge clk);
        vld   = 1'b0;
        edges = 1;
        while (ang_vld !== 1'b1 && edges < 10) begin
            @(negedge clk);
            edges++;
        end
        chk("latency", edges - 1, 32'd3);
        @(negedge clk);

        // Overrun: vld held across E0 and E1 -> one sample processed
        rt   = {16'h0050, 16'h1050};
        base = pulse_cnt;
        vld  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        vld = 1'b0;
        chk("ovr_set", {31'b0, ovr}, 32'h1);
        repeat (8) @(negedge clk);
        chk("ovr_pulses", pulse_cnt - base, 32'd1);
        chk("ovr_ang0", {16'b0, ang[15:0]}, 32'h0000FFFE);

        // clr together with vld: everything zero, vld dropped
        clr = 1'b1;
        vld = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        vld = 1'b0;
        chk("clr_ang", ang, 32'h0);
        chk("clr_ovr", {31'b0, ovr}, 32'h0);
        chk("clr_busy", {31'b0, busy}, 32'h0);
        chk("clr_ang_vld", {31'b0, ang_vld}, 32'h0);
        chk("clr_state", {30'b0, state_dbg}, 32'h0);
        base = pulse_cnt;
        repeat (6) @(negedge clk);
        chk("clr_no_pulse", pulse_cnt - base, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
